// File: rtl/conv_engine_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : conv_engine_seq
// Brief  : Sequential 2-D valid-mode convolution, one MAC per clock, with
//          stride, saturating/wrapping accumulation and a run cycle counter.
// Rev    : 1.0
// ============================================================================
module conv_engine_seq #(
  parameter int MAX_IN = 5,
  parameter int MAX_K  = 3,
  parameter int DW     = 8,
  parameter int ACCW   = 16,
  localparam int IMW   = $clog2(MAX_IN + 1),
  localparam int KMW   = $clog2(MAX_K + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IMW-1:0]                in_m,
  input  logic [IMW-1:0]                in_n,
  input  logic [KMW-1:0]                k_m,
  input  logic [KMW-1:0]                k_n,
  input  logic [1:0]                    stride,
  input  logic                          sat_en,
  input  logic [MAX_IN*MAX_IN*DW-1:0]   inputImage,
  input  logic [MAX_K*MAX_K*DW-1:0]     kernelMatrix,
  output logic [IMW-1:0]                out_m,
  output logic [IMW-1:0]                out_n,
  output logic [MAX_IN*MAX_IN*ACCW-1:0] convResult,
  output logic                          busy,
  output logic                          valid,
  output logic                          done,
  output logic [9:0]                    cycleCount,
  output logic                          dim_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MAC   = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IMW-1:0] c_in_lim = IMW'(MAX_IN);
  localparam logic [KMW-1:0] c_k_lim  = KMW'(MAX_K);

  state_t                      r_state, w_next;
  logic [IMW-1:0]              r_in_m, r_in_n, r_i, r_j;
  logic [KMW-1:0]              r_k_m, r_k_n, r_ki, r_kj;
  logic [1:0]                  r_stride;
  logic                        r_sat;
  logic [MAX_IN*MAX_IN*DW-1:0] r_img;
  logic [MAX_K*MAX_K*DW-1:0]   r_ker;
  logic [ACCW-1:0]             r_acc;

  logic                        w_err, w_k_last, w_j_last, w_i_last;
  logic [IMW-1:0]              w_dm, w_dn, w_om, w_on;
  int                          w_row, w_col, w_img_idx, w_ker_idx, w_res_idx;
  logic [2*DW-1:0]             w_prod;
  logic [ACCW:0]               w_sum;
  logic [ACCW-1:0]             w_acc_next;

  assign w_err = (r_in_m == '0) || (r_in_n == '0) || (r_k_m == '0) || (r_k_n == '0)
              || (r_in_m > c_in_lim) || (r_in_n > c_in_lim)
              || (r_k_m > c_k_lim) || (r_k_n > c_k_lim)
              || (r_in_m < IMW'(r_k_m)) || (r_in_n < IMW'(r_k_n))
              || !((r_stride == 2'd1) || (r_stride == 2'd2));

  // Stride is 1 or 2 on the error-free path, so floor division is a shift.
  assign w_dm = r_in_m - IMW'(r_k_m);
  assign w_dn = r_in_n - IMW'(r_k_n);
  assign w_om = ((r_stride == 2'd2) ? (w_dm >> 1) : w_dm) + IMW'(1);
  assign w_on = ((r_stride == 2'd2) ? (w_dn >> 1) : w_dn) + IMW'(1);

  assign w_row     = int'(r_i) * int'(r_stride) + int'(r_ki);
  assign w_col     = int'(r_j) * int'(r_stride) + int'(r_kj);
  assign w_img_idx = (w_row * MAX_IN + w_col) * DW;
  assign w_ker_idx = (int'(r_ki) * MAX_K + int'(r_kj)) * DW;
  assign w_res_idx = (int'(r_i) * MAX_IN + int'(r_j)) * ACCW;

  assign w_prod     = r_img[w_img_idx +: DW] * r_ker[w_ker_idx +: DW];
  assign w_sum      = (ACCW+1)'(r_acc) + (ACCW+1)'(w_prod);
  assign w_acc_next = (r_sat && w_sum[ACCW]) ? '1 : w_sum[ACCW-1:0];

  assign w_k_last = (r_ki == r_k_m - KMW'(1)) && (r_kj == r_k_n - KMW'(1));
  assign w_j_last = (r_j == out_n - IMW'(1));
  assign w_i_last = (r_i == out_m - IMW'(1));

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: w_next = w_err ? S_DONE : S_MAC;
      S_MAC:   if (w_k_last) w_next = S_STORE;
      S_STORE: w_next = (w_j_last && w_i_last) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_m <= '0; r_in_n <= '0; r_k_m <= '0; r_k_n <= '0;
      r_stride <= '0; r_sat <= 1'b0; r_img <= '0; r_ker <= '0;
      r_i <= '0; r_j <= '0; r_ki <= '0; r_kj <= '0; r_acc <= '0;
      out_m <= '0; out_n <= '0; convResult <= '0;
      valid <= 1'b0; dim_error <= 1'b0; cycleCount <= '0;
    end else begin
      if ((r_state == S_CHECK || r_state == S_MAC || r_state == S_STORE)
          && cycleCount != 10'h3FF)
        cycleCount <= cycleCount + 10'd1;
      case (r_state)
        S_IDLE: if (start) begin
          r_in_m <= in_m; r_in_n <= in_n; r_k_m <= k_m; r_k_n <= k_n;
          r_stride <= stride; r_sat <= sat_en;
          r_img <= inputImage; r_ker <= kernelMatrix;
          out_m <= '0; out_n <= '0; convResult <= '0;
          valid <= 1'b0; dim_error <= 1'b0; cycleCount <= '0;
        end
        S_CHECK: begin
          if (w_err) begin
            dim_error <= 1'b1;
          end else begin
            out_m <= w_om; out_n <= w_on;
          end
          r_i <= '0; r_j <= '0; r_ki <= '0; r_kj <= '0; r_acc <= '0;
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_kj == r_k_n - KMW'(1)) begin
            r_kj <= '0;
            r_ki <= r_ki + KMW'(1);
          end else begin
            r_kj <= r_kj + KMW'(1);
          end
        end
        S_STORE: begin
          convResult[w_res_idx +: ACCW] <= r_acc;
          r_acc <= '0; r_ki <= '0; r_kj <= '0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + IMW'(1);
          end else begin
            r_j <= r_j + IMW'(1);
          end
          // valid rises together with done on the way into DONE.
          if (w_j_last && w_i_last) valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_engine_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_conv_engine_seq
// Brief  : Directed self-checking bench for conv_engine_seq.
// Rev    : 1.0
// ============================================================================
module tb_conv_engine_seq;

  logic         clk = 1'b0;
  logic         reset, start, sat_en;
  logic [2:0]   in_m, in_n, out_m, out_n;
  logic [1:0]   k_m, k_n, stride;
  logic [199:0] inputImage;
  logic [71:0]  kernelMatrix;
  logic [399:0] convResult;
  logic         busy, valid, done, dim_error;
  logic [9:0]   cycleCount;

  int n_total = 0;
  int n_bad   = 0;

  conv_engine_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .in_m(in_m), .in_n(in_n), .k_m(k_m), .k_n(k_n),
    .stride(stride), .sat_en(sat_en),
    .inputImage(inputImage), .kernelMatrix(kernelMatrix),
    .out_m(out_m), .out_n(out_n), .convResult(convResult),
    .busy(busy), .valid(valid), .done(done),
    .cycleCount(cycleCount), .dim_error(dim_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] slot(input int i, input int j);
    return convResult[(i*5+j)*16 +: 16];
  endfunction

  task automatic set_cfg(input int im, input int inn, input int km, input int kn,
                         input int st, input logic sat);
    in_m = 3'(im); in_n = 3'(inn); k_m = 2'(km); k_n = 2'(kn);
    stride = 2'(st); sat_en = sat;
  endtask

  task automatic fill_const(input logic [7:0] iv, input logic [7:0] kv);
    for (int n = 0; n < 25; n++) inputImage[n*8 +: 8] = iv;
    for (int n = 0; n < 9; n++) kernelMatrix[n*8 +: 8] = kv;
  endtask

  // Pulses start, waits for done (optionally disturbing inputs mid-run),
  // then checks handshake timing and the status outputs.
  task automatic run_and_wait(input int disturb_at, input int exp_cc, input logic exp_err);
    int lat;
    lat = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("busy_after_start", {31'b0, busy}, 1);
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == disturb_at) begin
        start = 1'b1;
        set_cfg(3, 3, 1, 1, 2, 1'b1);
        fill_const(8'd2, 8'd7);
      end
      if (k == disturb_at + 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      check_val("timeout_done", {31'b0, done}, 1);
    end else begin
      check_val("done_latency", lat, exp_cc);
      check_val("valid_at_done", {31'b0, valid}, {31'b0, ~exp_err});
    end
    @(negedge clk);
    check_val("done_one_cycle", {31'b0, done}, 0);
    check_val("busy_dropped", {31'b0, busy}, 0);
    check_val("cycleCount", {22'b0, cycleCount}, exp_cc);
    check_val("dim_error", {31'b0, dim_error}, {31'b0, exp_err});
    check_val("valid_held", {31'b0, valid}, {31'b0, ~exp_err});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    fill_const(8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 0);
    check_val("rst_done", {31'b0, done}, 0);
    check_val("rst_valid", {31'b0, valid}, 0);
    check_val("rst_cc", {22'b0, cycleCount}, 0);
    check_val("rst_result_nz", {31'b0, |convResult}, 0);
    reset = 1'b0;

    // All ones 5x5 with 3x3 kernel.
    set_cfg(5, 5, 3, 3, 1, 1'b0);
    fill_const(8'd1, 8'd1);
    run_and_wait(-10, 91, 1'b0);
    check_val("t1_out_m", {29'b0, out_m}, 3);
    check_val("t1_out_n", {29'b0, out_n}, 3);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check_val("t1_elem", {16'b0, slot(i, j)}, 9);
    check_val("t1_unused_03", {16'b0, slot(0, 3)}, 0);
    check_val("t1_unused_30", {16'b0, slot(3, 0)}, 0);

    // Ramp image, 1x1 kernel of 2, stride 2.
    set_cfg(5, 5, 1, 1, 2, 1'b0);
    for (int n = 0; n < 25; n++) inputImage[n*8 +: 8] = 8'(n);
    kernelMatrix = '0;
    kernelMatrix[7:0] = 8'd2;
    run_and_wait(-10, 19, 1'b0);
    check_val("t2_out_m", {29'b0, out_m}, 3);
    check_val("t2_out_n", {29'b0, out_n}, 3);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check_val("t2_elem", {16'b0, slot(i, j)}, 2 * (10 * i + 2 * j));
    check_val("t2_elem22", {16'b0, slot(2, 2)}, 48);
    check_val("t2_unused_04", {16'b0, slot(0, 4)}, 0);
    check_val("t2_unused_44", {16'b0, slot(4, 4)}, 0);

    // 255s: wrap then saturate.
    set_cfg(3, 3, 3, 3, 1, 1'b0);
    fill_const(8'd255, 8'd255);
    run_and_wait(-10, 11, 1'b0);
    check_val("t3_wrap", {16'b0, slot(0, 0)}, 60937);
    check_val("t3_cleared_01", {16'b0, slot(0, 1)}, 0);
    check_val("t3_out_m", {29'b0, out_m}, 1);
    sat_en = 1'b1;
    run_and_wait(-10, 11, 1'b0);
    check_val("t3_sat", {16'b0, slot(0, 0)}, 65535);

    // Dimension errors.
    set_cfg(2, 2, 3, 3, 1, 1'b0);
    run_and_wait(-10, 1, 1'b1);
    check_val("t4_out_m", {29'b0, out_m}, 0);
    check_val("t4_out_n", {29'b0, out_n}, 0);
    check_val("t4_result_nz", {31'b0, |convResult}, 0);
    set_cfg(5, 5, 3, 3, 3, 1'b0);
    run_and_wait(-10, 1, 1'b1);
    set_cfg(5, 5, 0, 3, 1, 1'b0);
    run_and_wait(-10, 1, 1'b1);

    // start pulsed mid-run with different inputs is ignored.
    set_cfg(5, 5, 3, 3, 1, 1'b0);
    fill_const(8'd1, 8'd1);
    run_and_wait(10, 91, 1'b0);
    check_val("t6_out_m", {29'b0, out_m}, 3);
    check_val("t6_elem00", {16'b0, slot(0, 0)}, 9);
    check_val("t6_elem22", {16'b0, slot(2, 2)}, 9);

    // Asynchronous reset during the second element's MAC phase.
    set_cfg(5, 5, 3, 3, 1, 1'b0);
    fill_const(8'd1, 8'd1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    check_val("t7_pre_elem00", {16'b0, slot(0, 0)}, 9);
    #2 reset = 1'b1;
    #1;
    check_val("t7_async_busy", {31'b0, busy}, 0);
    check_val("t7_async_cc", {22'b0, cycleCount}, 0);
    check_val("t7_async_result", {31'b0, |convResult}, 0);
    check_val("t7_async_out_m", {29'b0, out_m}, 0);
    @(negedge clk); reset = 1'b0;
    set_cfg(5, 5, 1, 1, 2, 1'b0);
    for (int n = 0; n < 25; n++) inputImage[n*8 +: 8] = 8'(n);
    kernelMatrix = '0;
    kernelMatrix[7:0] = 8'd2;
    run_and_wait(-10, 19, 1'b0);
    check_val("t7_elem11", {16'b0, slot(1, 1)}, 24);
    check_val("t7_elem22", {16'b0, slot(2, 2)}, 48);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
